ddr_wr_burst_ctrl: RTL



---
 rtl/ddr_wr_burst_ctrl_if.sv | 62 ++++++
 rtl/ddr_wr_burst_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ddr_wr_burst_ctrl_if.sv
// Command, beat-source and DDR out-channel bundle for ddr_wr_burst_ctrl.
// master = the burst controller, slave = its environment.
interface ddr_wr_burst_ctrl_if #(
  parameter int DDR_W      = 512,
  parameter int DDR_ADDR_W = 32,
  parameter int BURST_W    = 8,
  parameter int LEN_W      = 16
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [DDR_ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]      cmd_len;

  logic [DDR_W-1:0]      wr_data;
  logic                  wr_valid;
  logic                  wr_ready;

  logic [DDR_ADDR_W-1:0] ddr_out_addr;
  logic [BURST_W-1:0]    ddr_out_size;
  logic                  ddr_out_addr_valid;
  logic                  ddr_out_addr_ready;

  logic [DDR_W-1:0]      ddr_out_data;
  logic                  ddr_out_valid;
  logic                  ddr_out_ready;

  modport master (
    input  cmd_valid,
    input  cmd_addr,
    input  cmd_len,
    output cmd_ready,
    input  wr_data,
    input  wr_valid,
    output wr_ready,
    output ddr_out_addr,
    output ddr_out_size,
    output ddr_out_addr_valid,
    input  ddr_out_addr_ready,
    output ddr_out_data,
    output ddr_out_valid,
    input  ddr_out_ready
  );

  modport slave (
    output cmd_valid,
    output cmd_addr,
    output cmd_len,
    input  cmd_ready,
    output wr_data,
    output wr_valid,
    input  wr_ready,
    input  ddr_out_addr,
    input  ddr_out_size,
    input  ddr_out_addr_valid,
    output ddr_out_addr_ready,
    input  ddr_out_data,
    input  ddr_out_valid,
    output ddr_out_ready
  );

endinterface

// File: rtl/ddr_wr_burst_ctrl.sv
// Write-side DDR master: splits a linear write command into bursts.
// Define DDR_4K_SPLIT_EN to keep every burst inside one 4 KB page.
module ddr_wr_burst_ctrl #(
  parameter int DDR_W      = 512,
  parameter int DDR_ADDR_W = 32,
  parameter int BURST_W    = 8,
  parameter int MAX_BURST  = 32,
  parameter int LEN_W      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  ddr_wr_burst_ctrl_if.master bus,
  output logic                busy,
  output logic                done
);

  localparam int BYTES = DDR_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam logic [DDR_ADDR_W-1:0] ALIGN =
    ~DDR_ADDR_W'(BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic [DDR_ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]      rem;
  logic [BURST_W-1:0]    bcnt;
  logic                  a_valid;
  logic [DDR_ADDR_W-1:0] a_addr;
  logic [BURST_W-1:0]    a_size;

  logic                  cmd_fire;
  logic                  a_fire;
  logic                  beat;
  logic                  last;
  logic [LEN_W-1:0]      lim;
  logic [BURST_W-1:0]    burst;
  logic [DDR_ADDR_W-1:0] inc;

  assign cmd_fire = (state == IDLE) & bus.cmd_valid;
  assign a_fire   = a_valid & bus.ddr_out_addr_ready;
  assign beat     = (state == DATA) & bus.wr_valid
                  & bus.ddr_out_ready;
  assign last     = beat & (bcnt == BURST_W'(1));
  assign inc      = DDR_ADDR_W'(a_size) << OFF_W;

`ifdef DDR_4K_SPLIT_EN
  logic [12:0]      to_4k;
  logic [LEN_W-1:0] beats_4k;

  // cur_addr is beat aligned, so the distance is a whole beat count
  assign to_4k    = 13'h1000 - {1'b0, cur_addr[11:0]};
  assign beats_4k = LEN_W'(to_4k >> OFF_W);

  always_comb begin
    lim = LEN_W'(MAX_BURST);
    if (rem < lim) lim = rem;
    if (beats_4k < lim) lim = beats_4k;
  end
`else
  always_comb begin
    lim = LEN_W'(MAX_BURST);
    if (rem < lim) lim = rem;
  end
`endif

  assign burst = BURST_W'(lim);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n       = state;
    bus.cmd_ready = 1'b0;
    done          = 1'b0;
    busy          = (state != IDLE);
    unique case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (cmd_fire) begin
          if (bus.cmd_len == '0) state_n = DONE;
          else                   state_n = ADDR;
        end
      end
      ADDR: begin
        if (a_fire) state_n = DATA;
      end
      DATA: begin
        if (last) begin
          if (rem == LEN_W'(1)) state_n = DONE;
          else                  state_n = ADDR;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.ddr_out_data  = bus.wr_data;
  assign bus.ddr_out_valid = (state == DATA) & bus.wr_valid;
  assign bus.wr_ready      = (state == DATA) & bus.ddr_out_ready;

  assign bus.ddr_out_addr       = a_addr;
  assign bus.ddr_out_size       = a_size;
  assign bus.ddr_out_addr_valid = a_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr <= '0;
      rem      <= '0;
      bcnt     <= '0;
      a_valid  <= 1'b0;
      a_addr   <= '0;
      a_size   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_fire) begin
            cur_addr <= bus.cmd_addr & ALIGN;
            rem      <= bus.cmd_len;
          end
        end
        ADDR: begin
          if (!a_valid) begin
            a_valid <= 1'b1;
            a_addr  <= cur_addr;
            a_size  <= burst;
          end else if (bus.ddr_out_addr_ready) begin
            a_valid <= 1'b0;
            bcnt    <= a_size;
          end
        end
        DATA: begin
          if (beat) begin
            bcnt <= bcnt - BURST_W'(1);
            rem  <= rem - LEN_W'(1);
            if (bcnt == BURST_W'(1))
              cur_addr <= cur_addr + inc;
          end
        end
        default: ;
      endcase
    end
  end

  // Address request must be held stable until accepted
  a_hold: assert property (
    @(posedge clk) disable iff (!rst_n)
    a_valid && !bus.ddr_out_addr_ready |=>
      a_valid && $stable(a_addr) && $stable(a_size)
  );

  a_size_nz: assert property (
    @(posedge clk) disable iff (!rst_n)
    a_valid |-> a_size != '0
  );

  a_bcnt_nz: assert property (
    @(posedge clk) disable iff (!rst_n)
    state == DATA |-> bcnt != '0
  );

endmodule
